alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the alu_arbiter and the shared combinational ALU.
// slave = arbiter side, master = requesters plus ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp_data;
  logic [2:0]        rsp_flags;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [2:0]        alu_flags;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
    input  rsp0_ready, rsp1_ready, alu_out, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
    output alu_a, alu_b, alu_ctrl, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
    output rsp0_ready, rsp1_ready, alu_out, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_flags,
    input  alu_a, alu_b, alu_ctrl, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round robin.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  // state | meaning
  // IDLE  | one requester's ready is high, waiting for its valid
  // EXEC  | operands drive the ALU for one cycle
  // RESP  | result held for the granted requester until it is consumed
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nx;
  logic              sel, accept, gnt_id;
  logic [WIDTH-1:0]  a_q, b_q, data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [2:0]        flags_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb sel = bus.req1_valid & ~bus.req0_valid;
`else
  logic last_gnt;

  // A lone valid always wins; otherwise the pointer picks the one not served last.
  always_comb begin
    if (bus.req0_valid && !bus.req1_valid)      sel = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid) sel = 1'b1;
    else                                        sel = ~last_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= 1'b1;
    else if (accept) last_gnt <= sel;
  end
`endif

  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = ~sel;
        bus.req1_ready = sel;
        accept         = sel ? bus.req1_valid : bus.req0_valid;
        if (accept) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        bus.rsp0_valid = ~gnt_id;
        bus.rsp1_valid = gnt_id;
        if (gnt_id ? bus.rsp1_ready : bus.rsp0_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      gnt_id  <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        a_q    <= sel ? bus.req1_a    : bus.req0_a;
        b_q    <= sel ? bus.req1_b    : bus.req0_b;
        ctrl_q <= sel ? bus.req1_ctrl : bus.req0_ctrl;
        gnt_id <= sel;
      end
      if (state == EXEC) begin
        data_q  <= bus.alu_out;
        flags_q <= bus.alu_flags;
      end
    end
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized operations
// against a transaction-level reference (grant pointer + expected ALU result).
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .CTRL_W(CW)) bus();
  alu_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  logic m_last;

  // Shared ALU: result plus flags {carry, zero, negative}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] c);
    logic [32:0] s;
    case (c)
      5'b10000: s = {1'b0, a} + {1'b0, b};
      5'b10001: s = {1'b0, a} - {1'b0, b};
      5'b00000: s = {1'b0, a & b};
      5'b00001: s = {1'b0, a | b};
      5'b00010: s = {1'b0, a ^ b};
      default:  s = {1'b0, a};
    endcase
    return {s[32], (s[31:0] == 32'd0), s[31], s[31:0]};
  endfunction

  assign {bus.alu_flags, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);

  function automatic logic exp_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v1 & ~v0;
`else
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
    return ~m_last;
`endif
  endfunction

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  // One complete operation: offer, accept, EXEC, RESP with `stall` back-pressure cycles.
  task automatic run_op(input string tag, input logic v0, input logic v1,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] c0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] c1,
                        input int stall, input logic use_exp, input logic [31:0] exp_d,
                        output logic obs_g);
    logic g;
    logic [31:0] ea, eb, ed;
    logic [4:0] ec;
    logic [34:0] r;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ctrl = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ctrl = c1;
    g  = exp_grant(v0, v1);
    ea = g ? a1 : a0; eb = g ? b1 : b0; ec = g ? c1 : c0;
    r  = alu_fn(ea, eb, ec);
    ed = use_exp ? exp_d : r[31:0];
    #1;
    obs_g = bus.req1_ready;
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== {g, ~g}) begin
      errors++; $display("FAIL %s grant: ready1/0 got %b%b want %b%b", tag, bus.req1_ready, bus.req0_ready, g, ~g);
    end
    @(posedge clk); #1;
    m_last = g;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    checks++;
    if ({bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid} !== 5'b10000) begin
      errors++; $display("FAIL %s exec: busy,rdy1,rdy0,rv1,rv0 got %b%b%b%b%b want 10000", tag, bus.busy, bus.req1_ready, bus.req0_ready, bus.rsp1_valid, bus.rsp0_valid);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_ctrl} !== {ea, eb, ec}) begin
      errors++; $display("FAIL %s alu_drive: got %0d %0d %b want %0d %0d %b", tag, bus.alu_a, bus.alu_b, bus.alu_ctrl, ea, eb, ec);
    end
    @(posedge clk); #1;
    if (g) begin bus.rsp1_ready = 0; bus.rsp0_ready = 1; end
    else   begin bus.rsp0_ready = 0; bus.rsp1_ready = 1; end
    checks++;
    if ({bus.rsp1_valid, bus.rsp0_valid} !== {g, ~g}) begin
      errors++; $display("FAIL %s rsp_valid: got %b%b want %b%b", tag, bus.rsp1_valid, bus.rsp0_valid, g, ~g);
    end
    checks++;
    if (bus.rsp_data !== ed || bus.rsp_flags !== r[34:32]) begin
      errors++; $display("FAIL %s rsp_data: got %0d/%b want %0d/%b", tag, bus.rsp_data, bus.rsp_flags, ed, r[34:32]);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp1_valid, bus.rsp0_valid} !== {g, ~g} || bus.rsp_data !== ed || bus.busy !== 1'b1 ||
          {bus.req1_ready, bus.req0_ready} !== 2'b00) begin
        errors++; $display("FAIL %s hold%0d: rv %b%b data %0d busy %b rdy %b%b want rv %b%b data %0d busy 1 rdy 00",
                           tag, i, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.busy, bus.req1_ready, bus.req0_ready, g, ~g, ed);
      end
    end
    if (g) bus.rsp1_ready = 1; else bus.rsp0_ready = 1;
    @(posedge clk); #1;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    checks++;
    if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid} !== 3'b000 || bus.rsp_data !== ed) begin
      errors++; $display("FAIL %s release: busy,rv1,rv0 %b%b%b data %0d want 000 data %0d", tag, bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, ed);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.rsp_flags, bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
      errors++; $display("FAIL reset_values: busy %b rv %b%b data %0d flags %b alu %0d %0d %b want all 0", bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.rsp_flags, bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    checks++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_ready: ready1/0 got %b%b want 01", bus.req1_ready, bus.req0_ready);
    end
  endtask

  task automatic test_single();
    logic og;
    run_op("single", 1, 0, 32'd512, 32'd512, 5'b10000, 0, 0, 0, 0, 1, 32'd1024, og);
  endtask

  task automatic test_both();
    logic og;
    do_reset();
    run_op("both_first", 1, 1, 32'd512, 32'd1024, 5'b10000, 32'd150, 32'd150, 5'b10000, 0, 1, 32'd1536, og);
    run_op("both_second", 0, 1, 0, 0, 0, 32'd150, 32'd150, 5'b10000, 1, 1, 32'd300, og);
  endtask

  task automatic test_order();
    logic og;
    logic seq [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_op("order", 1, 1, i, 7, 5'b10000, 100 + i, 9, 5'b10001, 0, 0, 0, og);
      checks++;
      if (og !== seq[i]) begin
        errors++; $display("FAIL order_op%0d: granted %b want %b", i, og, seq[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic og;
    run_op("backpressure", 1, 0, 32'd1243, 32'd10, 5'b10000, 0, 0, 0, 5, 1, 32'd1253, og);
  endtask

  task automatic test_wrong_ready();
    logic og;
    run_op("wrong_ready", 1, 0, 32'd77, 32'd3, 5'b10001, 0, 0, 0, 3, 1, 32'd74, og);
  endtask

  task automatic test_reset_mid_exec();
    logic og;
    logic seen;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 32'd999; bus.req0_b = 32'd1; bus.req0_ctrl = 5'b10000;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rst_exec_entry: busy got %b want 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.rsp_flags, bus.alu_a, bus.alu_b, bus.alu_ctrl} !== '0) begin
      errors++; $display("FAIL rst_async: busy %b rv %b%b data %0d alu %0d %0d %b want all 0", bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.alu_a, bus.alu_b, bus.alu_ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    bus.rsp0_ready = 1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) seen = 1'b1;
    end
    bus.rsp0_ready = 0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_no_rsp: stale activity got %b want 0", seen);
    end
    run_op("after_reset", 0, 1, 0, 0, 0, 32'd40, 32'd2, 5'b10000, 0, 1, 32'd42, og);
  endtask

  task automatic test_random();
    logic og, v0, v1;
    logic [4:0] ops [5];
    int p, ic;
    ops = '{5'b10000, 5'b10001, 5'b00000, 5'b00001, 5'b00010};
    for (int i = 0; i < 30; i++) begin
      ic = $urandom_range(0, 2);
      repeat (ic) begin
        @(negedge clk); #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== {exp_grant(0, 0), ~exp_grant(0, 0)}) begin
          errors++; $display("FAIL rand_idle_ready: got %b%b want %b%b", bus.req1_ready, bus.req0_ready, exp_grant(0, 0), ~exp_grant(0, 0));
        end
      end
      p = $urandom_range(1, 3);
      v0 = p[0]; v1 = p[1];
      run_op("random", v0, v1, $urandom, $urandom, ops[$urandom_range(0, 4)],
             $urandom, $urandom, ops[$urandom_range(0, 4)], $urandom_range(0, 3), 0, 0, og);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    m_last = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_both();
    test_order();
    test_back_pressure();
    test_wrong_ready();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
